// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Integer execute unit with a valid/ready request side and a
//            valid/ready result side. Single-cycle ADD/SUB/AND/XOR/SLL/SRA,
//            plus a multi-cycle radix-2 shift-add MUL (when MUL_EN = 1).
//            Undefined encodings complete as single-cycle ops flagged illegal.
// Ports    : clk_i, rst_i     - clock, synchronous active-high reset
//            valid_i/ready_o  - request handshake
//            funct_i[9:0]     - {funct7, funct3}
//            aluop_i[1:0]     - main-decoder op class
//            rs1_i, rs2_i     - operands (rs2_i already immediate-muxed)
//            valid_o/ready_i  - result handshake
//            result_o         - registered result
//            zero_o           - result_o == 0
//            illegal_o        - request had an undefined encoding
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [9:0]       funct_i,
    input  logic [1:0]       aluop_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam int c_sh_w  = $clog2(WIDTH);
    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_xor = 3'd3;
    localparam logic [2:0] c_op_sll = 3'd4;
    localparam logic [2:0] c_op_sra = 3'd5;
    localparam logic [2:0] c_op_mul = 3'd6;
    localparam logic [2:0] c_op_ill = 3'd7;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2:0]         w_op;
    logic [c_sh_w-1:0]  w_shamt;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_accept;
    logic               w_last_iter;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op = c_op_ill;
        case (aluop_i)
            2'b00:   w_op = (funct_i == 10'b0100000101) ? c_op_sra : c_op_add;
            2'b01:   w_op = c_op_sub;
            default: begin
                case (funct_i)
                    10'b0000000111: w_op = c_op_and;
                    10'b0000000100: w_op = c_op_xor;
                    10'b0000000001: w_op = c_op_sll;
                    10'b0000000000: w_op = c_op_add;
                    10'b0100000000: w_op = c_op_sub;
                    10'b0000001000: w_op = MUL_EN ? c_op_mul : c_op_ill;
                    default:        w_op = c_op_ill;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath (illegal encodings produce zero)
    // ------------------------------------------------------------------
    assign w_shamt = rs2_i[c_sh_w-1:0];

    always_comb begin
        w_alu_res = '0;
        case (w_op)
            c_op_add: w_alu_res = rs1_i + rs2_i;
            c_op_sub: w_alu_res = rs1_i - rs2_i;
            c_op_and: w_alu_res = rs1_i & rs2_i;
            c_op_xor: w_alu_res = rs1_i ^ rs2_i;
            c_op_sll: w_alu_res = rs1_i << w_shamt;
            c_op_sra: w_alu_res = $signed(rs1_i) >>> w_shamt;
            default:  w_alu_res = '0;
        endcase
    end

    // One multiplier bit per BUSY edge; the multiplicand shifts left so the
    // partial product always lines up with the accumulator.
    assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last_iter = (r_cnt == c_cnt_one);
    assign w_accept    = valid_i && (r_state == c_st_idle);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = (w_op == c_op_mul) ? c_st_busy : c_st_hold;
                end
            end
            c_st_busy: begin
                if (w_last_iter) begin
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                if (ready_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Result and multiplier registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            if (w_op == c_op_mul) begin
                r_acc    <= '0;
                r_mcand  <= rs1_i;
                r_mplier <= rs2_i;
                r_cnt    <= c_cnt_load;
            end else begin
                r_result  <= w_alu_res;
                r_zero    <= (w_alu_res == '0);
                r_illegal <= (w_op == c_op_ill);
            end
        end else if (r_state == c_st_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_cnt_one;
            if (w_last_iter) begin
                r_result  <= w_acc_nxt;
                r_zero    <= (w_acc_nxt == '0);
                r_illegal <= 1'b0;
            end
        end
    end

    assign ready_o   = (r_state == c_st_idle);
    assign valid_o   = (r_state == c_st_hold);
    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Scoreboard bench for alu_exec_unit (WIDTH = 32). Expected
//            responses are queued at issue time and checked by a monitor
//            whenever the unit presents a result. A second instance with
//            MUL_EN = 0 covers the disabled-multiplier encoding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [9:0]       funct_i;
    logic [1:0]       aluop_i;
    logic [WIDTH-1:0] rs1_i;
    logic [WIDTH-1:0] rs2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    logic             nm_valid_i;
    logic             nm_ready_o;
    logic             nm_valid_o;
    logic             nm_ready_i;
    logic [WIDTH-1:0] nm_result_o;
    logic             nm_zero_o;
    logic             nm_illegal_o;

    alu_exec_unit #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct_i(funct_i), .aluop_i(aluop_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .illegal_o(illegal_o)
    );

    alu_exec_unit #(.WIDTH(WIDTH), .MUL_EN(1'b0)) dut_nm (
        .clk_i(clk), .rst_i(rst_i), .valid_i(nm_valid_i), .ready_o(nm_ready_o),
        .funct_i(funct_i), .aluop_i(aluop_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .valid_o(nm_valid_o), .ready_i(nm_ready_i), .result_o(nm_result_o),
        .zero_o(nm_zero_o), .illegal_o(nm_illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
        int               lat;
        int               t0;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 1;   // 0/1 force ready_i, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: straight from the decode table and arithmetic rules.
    function automatic exp_t model(input logic [1:0] op, input logic [9:0] f,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   sh;
        logic [63:0] prod;
        sh = int'(b[4:0]);
        e.ill = 1'b0;
        e.lat = 1;
        e.res = '0;
        e.t0  = 0;
        if (op == 2'b00) begin
            if (f == 10'h105) e.res = WIDTH'($signed(a) >>> sh);
            else              e.res = a + b;
        end else if (op == 2'b01) begin
            e.res = a - b;
        end else begin
            case (f)
                10'h007: e.res = a & b;
                10'h004: e.res = a ^ b;
                10'h001: e.res = a << sh;
                10'h000: e.res = a + b;
                10'h100: e.res = a - b;
                10'h008: begin
                    prod  = 64'(a) * 64'(b);
                    e.res = prod[WIDTH-1:0];
                    e.lat = 1 + WIDTH;
                end
                default: e.ill = 1'b1;
            endcase
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        ready_i = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : rdy_mode[0];
    endtask

    // Waits (bounded) for ready_o, injecting ignored valid_i pulses while
    // the unit is occupied, then issues one request. Returns at the negedge
    // after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [9:0] f,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit inject);
        int   n;
        exp_t e;
        n = 0;
        while (!ready_o && n < 200) begin
            valid_i = inject && ($urandom_range(0, 3) == 0);
            aluop_i = 2'($urandom);
            funct_i = 10'($urandom);
            rs1_i   = $urandom;
            rs2_i   = $urandom;
            step();
            n++;
        end
        valid_i = 1'b0;
        if (!ready_o) begin
            check("ready_timeout", 64'(ready_o), 64'd1);
        end else begin
            aluop_i = op;
            funct_i = f;
            rs1_i   = a;
            rs2_i   = b;
            valid_i = 1'b1;
            e       = model(op, f, a, b);
            e.t0    = cyc;
            q.push_back(e);
            step();
            valid_i = 1'b0;
            rs1_i   = $urandom;
            rs2_i   = $urandom;
        end
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        logic             prev_v;
        logic             seen;
        logic [WIDTH-1:0] h_res;
        logic             h_zero;
        logic             h_ill;
        exp_t             e;
        prev_v = 1'b0;
        seen   = 1'b0;
        h_res  = '0;
        h_zero = 1'b0;
        h_ill  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                seen   = 1'b0;
                prev_v = 1'b0;
            end else begin
                if (prev_v && ready_i) begin
                    check("hs_ready_o", 64'(ready_o), 64'd1);
                    check("hs_valid_o", 64'(valid_o), 64'd0);
                    seen = 1'b0;
                end else if (valid_o) begin
                    if (!seen) begin
                        if (q.size() == 0) begin
                            check("unexpected_valid", 64'(valid_o), 64'd0);
                        end else begin
                            e = q.pop_front();
                            check("result", 64'(result_o), 64'(e.res));
                            check("zero", 64'(zero_o), 64'(e.zero));
                            check("illegal", 64'(illegal_o), 64'(e.ill));
                            check("latency", 64'(cyc - e.t0), 64'(e.lat));
                        end
                        h_res  = result_o;
                        h_zero = zero_o;
                        h_ill  = illegal_o;
                        seen   = 1'b1;
                    end else begin
                        check("hold_result", 64'(result_o), 64'(h_res));
                        check("hold_zero", 64'(zero_o), 64'(h_zero));
                        check("hold_illegal", 64'(illegal_o), 64'(h_ill));
                    end
                end
                prev_v = valid_o;
            end
        end
    end

    logic [9:0] c_fn_tab [0:8];

    initial begin
        int   n;
        logic [1:0]       op;
        logic [9:0]       f;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        c_fn_tab[0] = 10'h000; c_fn_tab[1] = 10'h100; c_fn_tab[2] = 10'h007;
        c_fn_tab[3] = 10'h004; c_fn_tab[4] = 10'h001; c_fn_tab[5] = 10'h008;
        c_fn_tab[6] = 10'h105; c_fn_tab[7] = 10'h003; c_fn_tab[8] = 10'h3FF;

        rst_i = 1'b1; valid_i = 1'b0; nm_valid_i = 1'b0; nm_ready_i = 1'b1;
        ready_i = 1'b1; funct_i = '0; aluop_i = '0; rs1_i = '0; rs2_i = '0;

        // Reset, with a valid_i pulse during reset that must be ignored.
        repeat (2) step();
        valid_i = 1'b1; aluop_i = 2'b10; rs1_i = 32'd1; rs2_i = 32'd2;
        step();
        valid_i = 1'b0;
        step();
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_result_o", 64'(result_o), 64'd0);
        check("rst_zero_o", 64'(zero_o), 64'd0);
        check("rst_illegal_o", 64'(illegal_o), 64'd0);
        rst_i = 1'b0;
        step();
        check("post_rst_valid_o", 64'(valid_o), 64'd0);

        // ADD 5 + 7
        rdy_mode = 1;
        issue(2'b10, 10'h000, 32'd5, 32'd7, 1'b0);
        check("add_valid", 64'(valid_o), 64'd1);
        check("add_result", 64'(result_o), 64'd12);
        check("add_zero", 64'(zero_o), 64'd0);
        step();
        check("add_ready_next", 64'(ready_o), 64'd1);

        // SUB to zero; SRA sign fill
        issue(2'b01, 10'h2A5, 32'd9, 32'd9, 1'b0);
        check("sub_result", 64'(result_o), 64'd0);
        check("sub_zero", 64'(zero_o), 64'd1);
        step();
        issue(2'b00, 10'h105, 32'h8000_0000, 32'd4, 1'b0);
        check("sra_result", 64'(result_o), 64'hF800_0000);
        step();

        // MUL 0xFFFFFFFF * 3 with an ignored mid-BUSY request
        issue(2'b10, 10'h008, 32'hFFFF_FFFF, 32'd3, 1'b0);
        for (int i = 0; i < 31; i++) begin
            check("busy_ready_o", 64'(ready_o), 64'd0);
            check("busy_valid_o", 64'(valid_o), 64'd0);
            valid_i = (i == 10);
            aluop_i = 2'b10; funct_i = 10'h000; rs1_i = 32'd1; rs2_i = 32'd1;
            step();
        end
        valid_i = 1'b0;
        step();
        check("mul_valid", 64'(valid_o), 64'd1);
        check("mul_result", 64'(result_o), 64'hFFFF_FFFD);
        step();

        // XOR held under back-pressure for 3 cycles
        rdy_mode = 0;
        issue(2'b10, 10'h004, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("xor_valid", 64'(valid_o), 64'd1);
            check("xor_result", 64'(result_o), 64'h0FF0_0FF0);
            if (k == 2) rdy_mode = 1;
            step();
        end
        check("xor_ready_after", 64'(ready_o), 64'd1);
        check("xor_valid_after", 64'(valid_o), 64'd0);

        // Illegal encoding
        issue(2'b10, 10'h003, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        check("ill_valid", 64'(valid_o), 64'd1);
        check("ill_flag", 64'(illegal_o), 64'd1);
        check("ill_result", 64'(result_o), 64'd0);
        step();

        // MUL on the MUL_EN = 0 instance
        aluop_i = 2'b10; funct_i = 10'h008; rs1_i = 32'd6; rs2_i = 32'd7;
        nm_valid_i = 1'b1;
        step();
        nm_valid_i = 1'b0;
        check("nomul_valid", 64'(nm_valid_o), 64'd1);
        check("nomul_illegal", 64'(nm_illegal_o), 64'd1);
        check("nomul_result", 64'(nm_result_o), 64'd0);
        step();

        // Reset on the 10th BUSY edge of a MUL
        issue(2'b11, 10'h008, $urandom, $urandom, 1'b0);
        repeat (9) step();
        rst_i = 1'b1;
        q.delete();
        step();
        rst_i = 1'b0;
        check("rst_busy_valid", 64'(valid_o), 64'd0);
        check("rst_busy_ready", 64'(ready_o), 64'd1);
        check("rst_busy_result", 64'(result_o), 64'd0);
        repeat (40) step();
        check("rst_busy_no_result", 64'(valid_o), 64'd0);

        // Reset while a result is presented
        rdy_mode = 0;
        issue(2'b10, 10'h000, 32'd3, 32'd4, 1'b0);
        check("rst_hold_valid_pre", 64'(valid_o), 64'd1);
        rst_i = 1'b1;
        q.delete();
        step();
        rst_i = 1'b0;
        check("rst_hold_valid", 64'(valid_o), 64'd0);
        step();

        // Randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int t = 0; t < 250; t++) begin
            op = 2'($urandom);
            f  = ($urandom_range(0, 9) == 0) ? 10'($urandom) : c_fn_tab[$urandom_range(0, 8)];
            if (f == 10'h008 && $urandom_range(0, 2) != 0) f = 10'h000;
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = a;
                default: b = $urandom;
            endcase
            issue(op, f, a, b, 1'b1);
        end

        // Drain
        rdy_mode = 1;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 200) begin
            step();
            n++;
        end
        check("drain_queue", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
